// File: rtl/rsa_pkg.sv
// Shared types and defaults for the RSA exponentiation scheduler.
package rsa_pkg;

    localparam int KEY_W_DEF = 2048;
    localparam int NREQ_DEF  = 4;
    localparam int ID_W_DEF  = 2;

    typedef logic [ID_W_DEF-1:0] id_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        BUSY   = 2'd2,
        RESP   = 2'd3
    } state_t;

endpackage

// File: rtl/rsa_rr_arb.sv
// Combinational round-robin picker: first asserted request at or after the
// pointer, wrapping modulo NREQ. The pointer register lives in the caller.
module rsa_rr_arb
    import rsa_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    parameter int ID_W = ID_W_DEF
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [ID_W-1:0] i_ptr,
    output logic [NREQ-1:0] o_grant,
    output logic [ID_W-1:0] o_idx,
    output logic            o_any
);

    // Requester index visited at each offset from the pointer.
    logic [ID_W-1:0] w_pos [NREQ];

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_pos
            assign w_pos[gi] = ID_W'((int'(i_ptr) + gi) % NREQ);
        end
    endgenerate

    // Scan from the farthest offset down so the nearest valid offset wins.
    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        o_any   = 1'b0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (i_req[w_pos[k]]) begin
                o_grant           = '0;
                o_grant[w_pos[k]] = 1'b1;
                o_idx             = w_pos[k];
                o_any             = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rsa_exp_sched.sv
// Round-robin scheduler sharing one modular-exponentiation engine between
// NREQ requesters. Optional watchdog abort enabled by RSA_SCHED_WDT_EN.
module rsa_exp_sched
    import rsa_pkg::*;
#(
    parameter int          KEY_W   = KEY_W_DEF,
    parameter int          NREQ    = NREQ_DEF,
    parameter int          ID_W    = ID_W_DEF,
    parameter logic [31:0] WDT_CYC = 32'd50_000_000
) (
    input  logic                  clk,
    input  logic                  sys_rst_n,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*KEY_W-1:0] req_c,
    input  logic [NREQ*KEY_W-1:0] req_e,
    input  logic [NREQ*KEY_W-1:0] req_n,
    output logic [KEY_W-1:0]      eng_c,
    output logic [KEY_W-1:0]      eng_e,
    output logic [KEY_W-1:0]      eng_n,
    output logic                  eng_start,
    input  logic [KEY_W-1:0]      eng_result,
    input  logic                  eng_finish,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [ID_W-1:0]       rsp_id,
    output logic [KEY_W-1:0]      rsp_data,
    output logic                  rsp_err,
    output logic                  busy
);

    state_t          r_state, w_state_next;
    logic [ID_W-1:0] r_ptr, r_id;
    logic [KEY_W-1:0] r_eng_c, r_eng_e, r_eng_n, r_rsp_data;
    logic            r_arm;
    logic [NREQ-1:0] w_grant, w_req_ready;
    logic [ID_W-1:0] w_idx;
    logic            w_any, w_take, w_fin_ok, w_done;
    logic [KEY_W-1:0] w_c_arr [NREQ];
    logic [KEY_W-1:0] w_e_arr [NREQ];
    logic [KEY_W-1:0] w_n_arr [NREQ];

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_slice
            assign w_c_arr[gi] = req_c[gi*KEY_W +: KEY_W];
            assign w_e_arr[gi] = req_e[gi*KEY_W +: KEY_W];
            assign w_n_arr[gi] = req_n[gi*KEY_W +: KEY_W];
        end
    endgenerate

    rsa_rr_arb #(
        .NREQ (NREQ),
        .ID_W (ID_W)
    ) u_arb (
        .i_req   (req_valid),
        .i_ptr   (r_ptr),
        .o_grant (w_grant),
        .o_idx   (w_idx),
        .o_any   (w_any)
    );

    assign w_take   = (r_state == IDLE) && w_any;
    // A finish only counts once the engine has been seen low since launch.
    assign w_fin_ok = (r_state == BUSY) && eng_finish && r_arm;

`ifdef RSA_SCHED_WDT_EN
    logic [31:0] r_wdt_cnt, w_wdt_inc;
    logic        w_wdt_hit, r_rsp_err;

    assign w_wdt_inc = (r_wdt_cnt == 32'hFFFF_FFFF) ? r_wdt_cnt : r_wdt_cnt + 32'd1;
    assign w_wdt_hit = (w_wdt_inc >= WDT_CYC);
    assign w_done    = w_fin_ok || ((r_state == BUSY) && w_wdt_hit);

    // Saturating BUSY-cycle counter, cleared each launch.
    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n)              r_wdt_cnt <= '0;
        else if (r_state == LAUNCH)  r_wdt_cnt <= '0;
        else if (r_state == BUSY)    r_wdt_cnt <= w_wdt_inc;
    end

    // Error flag captured with the response: set when the watchdog ended BUSY.
    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n)                     r_rsp_err <= 1'b0;
        else if ((r_state == BUSY) && w_done) r_rsp_err <= !w_fin_ok;
    end

    assign rsp_err = r_rsp_err;
`else
    logic [31:0] w_wdt_cfg_unused;
    assign w_wdt_cfg_unused = WDT_CYC;
    assign w_done  = w_fin_ok;
    assign rsp_err = 1'b0;
`endif

    // Next-state and grant decode.
    always_comb begin
        w_state_next = r_state;
        w_req_ready  = '0;
        case (r_state)
            IDLE: begin
                w_req_ready = w_grant;
                if (w_any) w_state_next = LAUNCH;
            end
            LAUNCH:  w_state_next = BUSY;
            BUSY:    if (w_done) w_state_next = RESP;
            RESP:    if (rsp_ready) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) r_state <= IDLE;
        else            r_state <= w_state_next;
    end

    // Latch the winner's operands and id, advance the round-robin pointer.
    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_eng_c <= '0;
            r_eng_e <= '0;
            r_eng_n <= '0;
            r_id    <= '0;
            r_ptr   <= '0;
        end else if (w_take) begin
            r_eng_c <= w_c_arr[w_idx];
            r_eng_e <= w_e_arr[w_idx];
            r_eng_n <= w_n_arr[w_idx];
            r_id    <= w_idx;
            r_ptr   <= (w_idx == ID_W'(NREQ - 1)) ? '0 : w_idx + ID_W'(1);
        end
    end

    // Arm flag: cleared at launch, set once finish is observed low in BUSY.
    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n)                          r_arm <= 1'b0;
        else if (r_state == LAUNCH)              r_arm <= 1'b0;
        else if ((r_state == BUSY) && !eng_finish) r_arm <= 1'b1;
    end

    // Capture the result on the BUSY->RESP transition; zero on abort.
    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n)                       r_rsp_data <= '0;
        else if ((r_state == BUSY) && w_done) r_rsp_data <= w_fin_ok ? eng_result : '0;
    end

    assign req_ready = sys_rst_n ? w_req_ready : '0;
    assign eng_c     = r_eng_c;
    assign eng_e     = r_eng_e;
    assign eng_n     = r_eng_n;
    assign eng_start = (r_state == LAUNCH);
    assign rsp_valid = (r_state == RESP);
    assign rsp_id    = r_id;
    assign rsp_data  = r_rsp_data;
    assign busy      = (r_state != IDLE);

endmodule

// File: tb/tb_rsa_exp_sched.sv
// Directed bench for rsa_exp_sched with a behavioural engine model.
// Build with RSA_SCHED_WDT_EN defined to also exercise the watchdog.
module tb_rsa_exp_sched;
    import rsa_pkg::*;

    localparam int KW = 16;
    localparam int NR = 4;
    localparam int IW = 2;

    logic            clk = 1'b0;
    logic            sys_rst_n = 1'b0;
    logic [NR-1:0]   req_valid = '0;
    logic [NR-1:0]   req_ready;
    logic [NR*KW-1:0] req_c = '0, req_e = '0, req_n = '0;
    logic [KW-1:0]   eng_c, eng_e, eng_n;
    logic            eng_start;
    logic [KW-1:0]   eng_result = '0;
    logic            eng_finish = 1'b0;
    logic            rsp_valid;
    logic            rsp_ready = 1'b0;
    logic [IW-1:0]   rsp_id;
    logic [KW-1:0]   rsp_data;
    logic            rsp_err;
    logic            busy;

    int n_checks = 0;
    int n_errors = 0;
    // 0: finish 20 cycles after start; 1: stale finish then real at 13; 2: never
    int eng_mode = 0;
    int m_cnt = 0;
    bit m_active = 1'b0;
    logic [KW-1:0] m_res = '0;

    rsa_exp_sched #(
        .KEY_W   (KW),
        .NREQ    (NR),
        .ID_W    (IW),
        .WDT_CYC (32'd100)
    ) dut (
        .clk        (clk),
        .sys_rst_n  (sys_rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_c      (req_c),
        .req_e      (req_e),
        .req_n      (req_n),
        .eng_c      (eng_c),
        .eng_e      (eng_e),
        .eng_n      (eng_n),
        .eng_start  (eng_start),
        .eng_result (eng_result),
        .eng_finish (eng_finish),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_data   (rsp_data),
        .rsp_err    (rsp_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [KW-1:0] f_modexp(input logic [KW-1:0] c, input logic [KW-1:0] e,
                                               input logic [KW-1:0] n);
        longint r, b, m;
        m = longint'(n);
        r = 1;
        b = longint'(c) % m;
        for (int i = 0; i < KW; i++) begin
            if (e[i]) r = (r * b) % m;
            b = (b * b) % m;
        end
        return KW'(r % m);
    endfunction

    // Engine model, stepped on the falling edge so it never races the DUT.
    always @(negedge clk) begin
        if (!sys_rst_n) begin
            m_active   = 1'b0;
            eng_finish = 1'b0;
        end else if (eng_start) begin
            m_active = 1'b1;
            m_cnt    = 0;
            m_res    = f_modexp(eng_c, eng_e, eng_n);
            if (eng_mode == 1) begin
                eng_finish = 1'b1;
                eng_result = 16'hDEAD;
            end else begin
                eng_finish = 1'b0;
                eng_result = 16'hBEEF;
            end
        end else if (m_active) begin
            m_cnt++;
            if (eng_mode == 0 && m_cnt == 20) begin
                eng_finish = 1'b1;
                eng_result = m_res;
            end else if (eng_mode == 1 && m_cnt == 3) begin
                eng_finish = 1'b0;
            end else if (eng_mode == 1 && m_cnt == 13) begin
                eng_finish = 1'b1;
                eng_result = m_res;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic set_ops(input int i, input logic [KW-1:0] c, input logic [KW-1:0] e,
                           input logic [KW-1:0] n);
        req_c[i*KW +: KW] = c;
        req_e[i*KW +: KW] = e;
        req_n[i*KW +: KW] = n;
    endtask

    // Raise a request and return just after the grant edge (state LAUNCH).
    task automatic send(input int i, input logic [KW-1:0] c, input logic [KW-1:0] e,
                        input logic [KW-1:0] n, output bit ok);
        set_ops(i, c, e, n);
        req_valid[i] = 1'b1;
        ok = 1'b0;
        for (int k = 0; k < 50; k++) begin
            #1;
            if (req_ready[i]) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        tick();
        req_valid[i] = 1'b0;
    endtask

    task automatic wait_rsp(input int max, output int cyc, output int pulses, output bit ok);
        cyc = 0;
        pulses = 0;
        while (!rsp_valid && cyc < max) begin
            if (eng_start) pulses++;
            tick();
            cyc++;
        end
        ok = rsp_valid;
        $display("tx id=%0d data=%0d err=%0d latency=%0d", rsp_id, rsp_data, rsp_err, cyc);
    endtask

    task automatic serve();
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        req_valid = 4'b0100;
        set_ops(2, 16'd3, 16'd3, 16'd7);
        repeat (3) tick();
        #1;
        n_checks++; if (req_ready !== 4'b0000) begin n_errors++; $display("FAIL rst_ready: got %b expected 0000", req_ready); end
        n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL rst_busy: got %b expected 0", busy); end
        n_checks++; if (eng_start !== 1'b0) begin n_errors++; $display("FAIL rst_start: got %b expected 0", eng_start); end
        n_checks++; if (rsp_valid !== 1'b0 || rsp_err !== 1'b0) begin n_errors++; $display("FAIL rst_rsp: got valid=%b err=%b expected 0 0", rsp_valid, rsp_err); end
        n_checks++; if (rsp_data !== 16'd0 || rsp_id !== 2'd0 || eng_c !== 16'd0) begin n_errors++; $display("FAIL rst_regs: got data=%0d id=%0d c=%0d expected 0", rsp_data, rsp_id, eng_c); end
        req_valid = '0;
        sys_rst_n = 1'b1;
        tick();
        n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL rst_idle: got busy=%b expected 0", busy); end
    endtask

    task automatic test_all_four();
        logic [KW-1:0] exp_d [4];
        int cyc, pulses;
        bit ok;
        exp_d[0] = 16'd24; exp_d[1] = 16'd4; exp_d[2] = 16'd8; exp_d[3] = 16'd5;
        set_ops(0, 16'd2, 16'd10, 16'd1000);
        set_ops(1, 16'd3, 16'd4,  16'd7);
        set_ops(2, 16'd5, 16'd3,  16'd13);
        set_ops(3, 16'd7, 16'd2,  16'd11);
        req_valid = 4'b1111;
        for (int r = 0; r < 4; r++) begin
            #1;
            n_checks++; if (req_ready !== (4'b0001 << r)) begin n_errors++; $display("FAIL rr_grant%0d: got %b expected %b", r, req_ready, 4'b0001 << r); end
            tick();
            req_valid[r] = 1'b0;
            wait_rsp(60, cyc, pulses, ok);
            n_checks++; if (ok !== 1'b1) begin n_errors++; $display("FAIL rr_timeout%0d: got no response expected one", r); end
            n_checks++; if (rsp_id !== IW'(r)) begin n_errors++; $display("FAIL rr_id%0d: got %0d expected %0d", r, rsp_id, r); end
            n_checks++; if (rsp_data !== exp_d[r]) begin n_errors++; $display("FAIL rr_data%0d: got %0d expected %0d", r, rsp_data, exp_d[r]); end
            serve();
        end
        // Pointer has wrapped back to 0: 0 beats 3.
        req_valid = 4'b1001;
        #1;
        n_checks++; if (req_ready !== 4'b0001) begin n_errors++; $display("FAIL wrap_grant0: got %b expected 0001", req_ready); end
        tick();
        req_valid[0] = 1'b0;
        wait_rsp(60, cyc, pulses, ok);
        n_checks++; if (rsp_id !== 2'd0) begin n_errors++; $display("FAIL wrap_id0: got %0d expected 0", rsp_id); end
        serve();
        #1;
        n_checks++; if (req_ready !== 4'b1000) begin n_errors++; $display("FAIL wrap_grant3: got %b expected 1000", req_ready); end
        tick();
        req_valid[3] = 1'b0;
        wait_rsp(60, cyc, pulses, ok);
        n_checks++; if (rsp_id !== 2'd3 || rsp_data !== 16'd5) begin n_errors++; $display("FAIL wrap_rsp3: got id=%0d data=%0d expected 3 5", rsp_id, rsp_data); end
        serve();
    endtask

    task automatic test_single();
        int cyc, pulses;
        bit ok, ok2;
        send(1, 16'd4, 16'd13, 16'd497, ok);
        n_checks++; if (ok !== 1'b1) begin n_errors++; $display("FAIL single_grant: got no grant expected grant"); end
        n_checks++; if (eng_c !== 16'd4 || eng_e !== 16'd13 || eng_n !== 16'd497) begin n_errors++; $display("FAIL single_ops: got %0d %0d %0d expected 4 13 497", eng_c, eng_e, eng_n); end
        wait_rsp(60, cyc, pulses, ok2);
        n_checks++; if (ok2 !== 1'b1) begin n_errors++; $display("FAIL single_timeout: got no response expected one"); end
        // One LAUNCH cycle plus 20 BUSY cycles.
        n_checks++; if (cyc !== 21) begin n_errors++; $display("FAIL single_latency: got %0d expected 21", cyc); end
        n_checks++; if (pulses !== 1) begin n_errors++; $display("FAIL single_pulses: got %0d expected 1", pulses); end
        n_checks++; if (rsp_id !== 2'd1 || rsp_data !== 16'd445 || rsp_err !== 1'b0) begin n_errors++; $display("FAIL single_rsp: got id=%0d data=%0d err=%b expected 1 445 0", rsp_id, rsp_data, rsp_err); end
        serve();
        #1;
        n_checks++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin n_errors++; $display("FAIL single_drop: got valid=%b busy=%b expected 0 0", rsp_valid, busy); end
    endtask

    task automatic test_stale_finish();
        int cyc, pulses;
        bit ok, ok2;
        eng_mode = 1;
        send(2, 16'd6, 16'd2, 16'd11, ok);
        wait_rsp(60, cyc, pulses, ok2);
        n_checks++; if (ok !== 1'b1 || ok2 !== 1'b1) begin n_errors++; $display("FAIL stale_timeout: got grant=%b rsp=%b expected 1 1", ok, ok2); end
        // Second finish appears 13 cycles after start: LAUNCH + 13 BUSY.
        n_checks++; if (cyc !== 14) begin n_errors++; $display("FAIL stale_latency: got %0d expected 14", cyc); end
        n_checks++; if (rsp_data !== 16'd3 || rsp_id !== 2'd2) begin n_errors++; $display("FAIL stale_rsp: got id=%0d data=%0d expected 2 3", rsp_id, rsp_data); end
        serve();
        eng_mode = 0;
    endtask

    task automatic test_backpressure();
        int cyc, pulses;
        bit ok, ok2, stable, leak;
        send(3, 16'd9, 16'd2, 16'd50, ok);
        wait_rsp(60, cyc, pulses, ok2);
        n_checks++; if (ok2 !== 1'b1) begin n_errors++; $display("FAIL bp_timeout: got no response expected one"); end
        set_ops(1, 16'd4, 16'd13, 16'd497);
        req_valid[1] = 1'b1;
        stable = 1'b1;
        leak = 1'b0;
        repeat (15) begin
            #1;
            if (rsp_valid !== 1'b1 || rsp_id !== 2'd3 || rsp_data !== 16'd31 || rsp_err !== 1'b0) stable = 1'b0;
            if (req_ready !== 4'b0000) leak = 1'b1;
            tick();
        end
        n_checks++; if (stable !== 1'b1) begin n_errors++; $display("FAIL bp_stable: got unstable response expected id=3 data=31 held"); end
        n_checks++; if (leak !== 1'b0) begin n_errors++; $display("FAIL bp_ready_leak: got req_ready during stall expected none"); end
        serve();
        #1;
        n_checks++; if (rsp_valid !== 1'b0 || req_ready !== 4'b0010) begin n_errors++; $display("FAIL bp_resume: got valid=%b ready=%b expected 0 0010", rsp_valid, req_ready); end
        tick();
        req_valid[1] = 1'b0;
        wait_rsp(60, cyc, pulses, ok2);
        n_checks++; if (rsp_id !== 2'd1 || rsp_data !== 16'd445) begin n_errors++; $display("FAIL bp_next: got id=%0d data=%0d expected 1 445", rsp_id, rsp_data); end
        serve();
    endtask

    task automatic test_reset_mid_busy();
        int cyc, pulses;
        bit ok, ok2;
        eng_mode = 2;
        send(0, 16'd2, 16'd10, 16'd1000, ok);
        repeat (5) tick();
        n_checks++; if (busy !== 1'b1 || eng_c !== 16'd2) begin n_errors++; $display("FAIL mid_busy: got busy=%b c=%0d expected 1 2", busy, eng_c); end
        sys_rst_n = 1'b0;
        #1;
        n_checks++; if (busy !== 1'b0 || eng_start !== 1'b0 || rsp_valid !== 1'b0 || req_ready !== 4'b0000) begin n_errors++; $display("FAIL mid_rst_ctl: got busy=%b start=%b valid=%b ready=%b expected 0", busy, eng_start, rsp_valid, req_ready); end
        n_checks++; if (eng_c !== 16'd0 || rsp_data !== 16'd0 || rsp_id !== 2'd0) begin n_errors++; $display("FAIL mid_rst_regs: got c=%0d data=%0d id=%0d expected 0", eng_c, rsp_data, rsp_id); end
        repeat (2) tick();
        sys_rst_n = 1'b1;
        tick();
        n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL mid_idle: got busy=%b expected 0", busy); end
        eng_mode = 0;
        send(2, 16'd2, 16'd10, 16'd1000, ok);
        wait_rsp(60, cyc, pulses, ok2);
        n_checks++; if (ok2 !== 1'b1 || pulses !== 1 || rsp_id !== 2'd2 || rsp_data !== 16'd24) begin n_errors++; $display("FAIL mid_after: got ok=%b pulses=%0d id=%0d data=%0d expected 1 1 2 24", ok2, pulses, rsp_id, rsp_data); end
        serve();
    endtask

`ifdef RSA_SCHED_WDT_EN
    task automatic test_watchdog();
        int cyc, pulses;
        bit ok, ok2;
        eng_mode = 2;
        send(1, 16'd4, 16'd13, 16'd497, ok);
        wait_rsp(300, cyc, pulses, ok2);
        n_checks++; if (ok2 !== 1'b1) begin n_errors++; $display("FAIL wdt_timeout: got no response expected abort"); end
        // One LAUNCH cycle plus 100 BUSY cycles.
        n_checks++; if (cyc !== 101) begin n_errors++; $display("FAIL wdt_latency: got %0d expected 101", cyc); end
        n_checks++; if (rsp_err !== 1'b1 || rsp_data !== 16'd0 || rsp_id !== 2'd1) begin n_errors++; $display("FAIL wdt_rsp: got err=%b data=%0d id=%0d expected 1 0 1", rsp_err, rsp_data, rsp_id); end
        serve();
        eng_mode = 0;
    endtask
`endif

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "bench timed out");
    end

    initial begin
        test_reset();
        test_all_four();
        test_single();
        test_stale_finish();
        test_backpressure();
        test_reset_mid_busy();
`ifdef RSA_SCHED_WDT_EN
        test_watchdog();
`endif
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
